axi_wr_arbiter: RTL and testbench
=================================

# axi_wr_arbiter

Four-to-one round-robin arbiter that shares a single AXI write port (AW/W/B) of the consumer among four upstream write masters. It orders write data to match address acceptance and routes write responses back by ID prefix. It sits between the producer-side write masters and the consumer's write slave port.

## Interface
- ID_W, 4, upstream AXI ID width; downstream ID is ID_W+2 bits (source index prepended as MSBs).
- ADDR_W, 32, address width.
- DATA_W, 64, data width; strobe width DATA_W/8.
- WFIFO_DEPTH, 4, entries in the W-order FIFO (power of 2, ≥2).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_awvalid / s_awready  in / out  [3:0]  per-source AW handshake.
- s_awid / s_awaddr / s_awlen  in  [4][ID_W] / [4][ADDR_W] / [4][8]  per-source AW payload.
- s_wvalid / s_wready / s_wlast  in / out / in  [3:0]  per-source W handshake and last flag.
- s_wdata / s_wstrb  in  [4][DATA_W] / [4][DATA_W/8]  per-source W payload.
- s_bvalid / s_bready  out / in  [3:0]  per-source B handshake.
- s_bid / s_bresp  out  [ID_W] / [2]  B payload, shared by all sources.
- m_awvalid / m_awready  out / in  1  downstream AW handshake.
- m_awid / m_awaddr / m_awlen  out  [ID_W+2] / [ADDR_W] / [8]  downstream AW payload.
- m_wvalid / m_wready / m_wlast  out / in / out  1  downstream W.
- m_wdata / m_wstrb  out  [DATA_W] / [DATA_W/8]  downstream W payload.
- m_bvalid / m_bready  in / out  1  downstream B handshake.
- m_bid / m_bresp  in  [ID_W+2] / [2]  downstream B payload.
- burst_cnt  out  [4][16]  per-source accepted-burst counters (see Configuration).

## Operation
- AW FSM, two states. ARB: if any s_awvalid and W FIFO not full, pick first requester at or after rr_ptr (wrapping 3→0), register grant, go to SEND. SEND: m_awvalid=1, payload muxed from granted source, m_awid={grant[1:0], s_awid[grant]}; s_awready[grant]=m_awready; on m_awready: push grant into W FIFO, rr_ptr=grant+1 (mod 4), return to ARB.
- Sources may not drop awvalid once asserted (AXI rule); grant is never revoked in SEND.
- W FIFO full: stay in ARB, no grant, all s_awready=0.
- W routing: when FIFO non-empty, head index h selects source; m_wvalid=s_wvalid[h], s_wready[h]=m_wready, other s_wready=0. Pop on m_wvalid&m_wready&m_wlast. FIFO empty: m_wvalid=0, all s_wready=0. A source's W beats are stalled until its AW reaches the FIFO head.
- B routing (combinational): s_bvalid[i]=m_bvalid&(m_bid[ID_W+1:ID_W]==i); m_bready=s_bready[m_bid[ID_W+1:ID_W]]; s_bid=m_bid[ID_W-1:0]; s_bresp=m_bresp.
- Push and pop in the same cycle allowed when not full; count unchanged.

## Timing
- Reset values: state=ARB, rr_ptr=0, FIFO empty, m_awvalid=0, m_wvalid=0, s_awready=0, s_wready=0, burst_cnt=0.
- AW latency: request in ARB cycle → m_awvalid next cycle; minimum 2 cycles per AW (one burst per 2 cycles peak).
- W: zero added latency; first beat can pass the cycle after the AW handshake.
- B: zero latency, pass-through.
- Reset mid-burst clears all state immediately; downstream and upstream must be reset in the same cycle.

## Configuration
- AXI_WR_ARB_STATS_EN defined: burst_cnt[i] increments on each AW handshake of source i, saturates at 16'hFFFF, cleared by rst.
- Not defined: burst_cnt tied to 0, no counter flops.

## Test plan
- Single source 2, awaddr=0x100, awlen=3, 4 W beats -> m_awid={2'd2,id}, 4 beats forwarded, m_wlast on beat 4, B with bid MSBs=2 reaches s_bvalid[2] only.
- All four sources request continuously -> grant order 0,1,2,3,0,...; each source 1 AW per 8 cycles.
- Source 1 presents W before AW, source 0 AW first -> s_wready[1]=0 until source 0's burst last beat; then source 1 data flows.
- Hold m_wready=0, issue 5 AWs with WFIFO_DEPTH=4 -> 4 AWs accepted, 5th waits in ARB with s_awready=0 until first wlast pops.
- Assert rst for 1 cycle during SEND with m_awready=0 -> all outputs at reset values next cycle, rr_ptr=0.
- With AXI_WR_ARB_STATS_EN, 3 bursts from source 3 -> burst_cnt[3]=3, others 0; preload-to-0xFFFF case stays 0xFFFF.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Four-source round-robin arbiter for one AXI write port (AW/W/B).
// Optional per-source burst counters are built when AXI_WR_ARB_STATS_EN is defined.

`ifdef AXI_WR_ARB_STATS_EN
module axi_wr_arb_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    output logic [15:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end
endmodule
`endif

module axi_wr_arbiter #(
    parameter int ID_W        = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int WFIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    s_awvalid,
    output logic [3:0]                    s_awready,
    input  logic [3:0][ID_W-1:0]          s_awid,
    input  logic [3:0][ADDR_W-1:0]        s_awaddr,
    input  logic [3:0][7:0]               s_awlen,
    input  logic [3:0]                    s_wvalid,
    output logic [3:0]                    s_wready,
    input  logic [3:0]                    s_wlast,
    input  logic [3:0][DATA_W-1:0]        s_wdata,
    input  logic [3:0][DATA_W/8-1:0]      s_wstrb,
    output logic [3:0]                    s_bvalid,
    input  logic [3:0]                    s_bready,
    output logic [ID_W-1:0]               s_bid,
    output logic [1:0]                    s_bresp,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [ID_W+1:0]               m_awid,
    output logic [ADDR_W-1:0]             m_awaddr,
    output logic [7:0]                    m_awlen,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    output logic                          m_wlast,
    output logic [DATA_W-1:0]             m_wdata,
    output logic [DATA_W/8-1:0]           m_wstrb,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    input  logic [ID_W+1:0]               m_bid,
    input  logic [1:0]                    m_bresp,
    output logic [3:0][15:0]              burst_cnt
);
    localparam int PW = $clog2(WFIFO_DEPTH);

    typedef enum logic {ARB, SEND} state_t;

    state_t      state, state_nxt;
    logic [1:0]  grant, grant_nxt, rr_ptr;
    logic [1:0]  pick;
    logic        pick_vld;
    logic [1:0]  fifo_mem [WFIFO_DEPTH];
    logic [PW:0] wr_ptr, rd_ptr;
    logic        full, empty, aw_hs, pop;
    logic [1:0]  head, bsrc;

    assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = fifo_mem[rd_ptr[PW-1:0]];
    assign aw_hs = (state == SEND) && m_awready;
    assign pop   = !empty && s_wvalid[head] && m_wready && s_wlast[head];

    // Round-robin search starting at rr_ptr, wrapping 3 -> 0.
    always_comb begin
        logic [1:0] idx;
        idx      = '0;
        pick     = rr_ptr;
        pick_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!pick_vld && s_awvalid[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            ARB: if (pick_vld && !full) begin
                grant_nxt = pick;
                state_nxt = SEND;
            end
            SEND: if (m_awready) state_nxt = ARB;
            default: state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB;
            grant  <= '0;
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (aw_hs) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= grant + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Order storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && aw_hs) fifo_mem[wr_ptr[PW-1:0]] <= grant;
    end

    assign m_awvalid = (state == SEND);
    assign m_awid    = {grant, s_awid[grant]};
    assign m_awaddr  = s_awaddr[grant];
    assign m_awlen   = s_awlen[grant];

    always_comb begin
        s_awready = '0;
        if (state == SEND) s_awready[grant] = m_awready;
        s_wready = '0;
        if (!empty) s_wready[head] = m_wready;
    end

    assign m_wvalid = !empty && s_wvalid[head];
    assign m_wlast  = s_wlast[head];
    assign m_wdata  = s_wdata[head];
    assign m_wstrb  = s_wstrb[head];

    // Responses route by the source index carried in the upper ID bits.
    assign bsrc     = m_bid[ID_W+1:ID_W];
    assign m_bready = s_bready[bsrc];
    assign s_bid    = m_bid[ID_W-1:0];
    assign s_bresp  = m_bresp;

    always_comb begin
        for (int i = 0; i < 4; i++)
            s_bvalid[i] = m_bvalid && (bsrc == 2'(i));
    end

`ifdef AXI_WR_ARB_STATS_EN
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        axi_wr_arb_cnt u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (aw_hs && (grant == 2'(gi))),
            .cnt (burst_cnt[gi])
        );
    end
`else
    assign burst_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed self-checking bench for axi_wr_arbiter (default parameters).
// Build with AXI_WR_ARB_STATS_EN to exercise the burst counters.
module tb_axi_wr_arbiter;
    localparam int ID_W = 4, ADDR_W = 32, DATA_W = 64;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [3:0]               s_awvalid, s_awready;
    logic [3:0][ID_W-1:0]     s_awid;
    logic [3:0][ADDR_W-1:0]   s_awaddr;
    logic [3:0][7:0]          s_awlen;
    logic [3:0]               s_wvalid, s_wready, s_wlast;
    logic [3:0][DATA_W-1:0]   s_wdata;
    logic [3:0][DATA_W/8-1:0] s_wstrb;
    logic [3:0]               s_bvalid, s_bready;
    logic [ID_W-1:0]          s_bid;
    logic [1:0]               s_bresp;
    logic                     m_awvalid, m_awready;
    logic [ID_W+1:0]          m_awid;
    logic [ADDR_W-1:0]        m_awaddr;
    logic [7:0]               m_awlen;
    logic                     m_wvalid, m_wready, m_wlast;
    logic [DATA_W-1:0]        m_wdata;
    logic [DATA_W/8-1:0]      m_wstrb;
    logic                     m_bvalid, m_bready;
    logic [ID_W+1:0]          m_bid;
    logic [1:0]               m_bresp;
    logic [3:0][15:0]         burst_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    axi_wr_arbiter dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
        .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
        .burst_cnt(burst_cnt)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_awvalid = '0; s_awid = '0; s_awaddr = '0; s_awlen = '0;
        s_wvalid = '0; s_wlast = '0; s_wdata = '0; s_wstrb = '1;
        s_bready = '0; m_awready = 1'b0; m_wready = 1'b0;
        m_bvalid = 1'b0; m_bid = '0; m_bresp = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_tests++;
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || s_awready !== 4'b0 || s_wready !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: awv=%b wv=%b awr=%b wr=%b want all 0",
                     m_awvalid, m_wvalid, s_awready, s_wready);
        end
        n_tests++;
        if (burst_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h want 0", burst_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1;
        s_awvalid[2] = 1'b1; s_awid[2] = 4'h5; s_awaddr[2] = 32'h100; s_awlen[2] = 8'd3;
        #1;
        n_tests++;
        if (m_awvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_arb_cycle: m_awvalid=%b want 0", m_awvalid);
        end
        @(negedge clk); #1;
        n_tests++;
        if (m_awvalid !== 1'b1 || m_awid !== 6'h25 || m_awaddr !== 32'h100 ||
            m_awlen !== 8'd3 || s_awready !== 4'b0100) begin
            n_fail++;
            $display("FAIL single_aw: v=%b id=%h addr=%h len=%0d awr=%b want 1 25 100 3 0100",
                     m_awvalid, m_awid, m_awaddr, m_awlen, s_awready);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            s_awvalid[2] = 1'b0;
            s_wvalid[2] = 1'b1; s_wdata[2] = 64'hA0 + 64'(b); s_wlast[2] = (b == 3);
            #1;
            n_tests++;
            if (m_wvalid !== 1'b1 || m_wdata !== 64'hA0 + 64'(b) ||
                m_wlast !== (b == 3) || s_wready !== 4'b0100) begin
                n_fail++;
                $display("FAIL single_w_beat%0d: v=%b d=%h last=%b wr=%b want 1 %h %b 0100",
                         b, m_wvalid, m_wdata, m_wlast, s_wready, 64'hA0 + 64'(b), (b == 3));
            end
        end
        @(negedge clk); #1;
        n_tests++;
        if (m_wvalid !== 1'b0 || s_wready !== 4'b0) begin
            n_fail++;
            $display("FAIL single_w_drained: v=%b wr=%b want 0 0000", m_wvalid, s_wready);
        end
        s_wvalid = '0;
        m_bvalid = 1'b1; m_bid = 6'h25; m_bresp = 2'b01; s_bready = 4'b0100;
        #1;
        n_tests++;
        if (s_bvalid !== 4'b0100 || s_bid !== 4'h5 || s_bresp !== 2'b01 || m_bready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_b: bv=%b bid=%h resp=%b brdy=%b want 0100 5 01 1",
                     s_bvalid, s_bid, s_bresp, m_bready);
        end
        s_bready = 4'b1011;
        #1;
        n_tests++;
        if (m_bready !== 1'b0) begin
            n_fail++; $display("FAIL single_b_bready: got %b want 0", m_bready);
        end
        m_bvalid = 1'b0;
    endtask

    task automatic test_round_robin();
        int n_grants = 0;
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1;
        s_wvalid = 4'hF; s_wlast = 4'hF;
        for (int i = 0; i < 4; i++) s_awid[i] = 4'(i);
        s_awvalid = 4'hF;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk); #1;
            if (m_awvalid) begin
                n_tests++;
                if (m_awid !== {2'(n_grants % 4), 4'(n_grants % 4)} || (c % 2) != 1) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: id=%h cycle=%0d want id=%h odd cycle",
                             n_grants, m_awid, c, {2'(n_grants % 4), 4'(n_grants % 4)});
                end
                n_grants++;
            end
        end
        n_tests++;
        if (n_grants != 8) begin
            n_fail++; $display("FAIL rr_count: got %0d grants want 8", n_grants);
        end
    endtask

    task automatic test_w_order();
        do_reset();
        m_awready = 1'b1; m_wready = 1'b1;
        s_wvalid[1] = 1'b1; s_wlast[1] = 1'b1; s_wdata[1] = 64'h1111;
        s_awvalid[0] = 1'b1; s_awlen[0] = 8'd1;
        #1;
        n_tests++;
        if (s_wready[1] !== 1'b0 || m_wvalid !== 1'b0) begin
            n_fail++; $display("FAIL order_early_w: wr1=%b mwv=%b want 0 0", s_wready[1], m_wvalid);
        end
        @(negedge clk);
        s_awvalid[1] = 1'b1;
        @(negedge clk);
        s_awvalid[0] = 1'b0;
        s_wvalid[0] = 1'b1; s_wdata[0] = 64'h0A; s_wlast[0] = 1'b0;
        #1;
        n_tests++;
        if (s_wready !== 4'b0001 || m_wdata !== 64'h0A) begin
            n_fail++; $display("FAIL order_src0_beat0: wr=%b d=%h want 0001 0a", s_wready, m_wdata);
        end
        @(negedge clk);
        s_wdata[0] = 64'h0B; s_wlast[0] = 1'b1;
        #1;
        n_tests++;
        if (s_wready !== 4'b0001 || m_wlast !== 1'b1 || m_awvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL order_src0_last: wr=%b last=%b awv=%b want 0001 1 1", s_wready, m_wlast, m_awvalid);
        end
        @(negedge clk);
        s_wvalid[0] = 1'b0; s_awvalid[1] = 1'b0;
        #1;
        n_tests++;
        if (s_wready !== 4'b0010 || m_wvalid !== 1'b1 || m_wdata !== 64'h1111 || m_wlast !== 1'b1) begin
            n_fail++;
            $display("FAIL order_src1_flow: wr=%b v=%b d=%h last=%b want 0010 1 1111 1",
                     s_wready, m_wvalid, m_wdata, m_wlast);
        end
        @(negedge clk); #1;
        n_tests++;
        if (m_wvalid !== 1'b0 || s_wready !== 4'b0) begin
            n_fail++; $display("FAIL order_drained: v=%b wr=%b want 0 0000", m_wvalid, s_wready);
        end
        s_wvalid = '0;
    endtask

    task automatic test_fifo_full();
        int n_hs = 0;
        do_reset();
        m_awready = 1'b1; m_wready = 1'b0;
        s_wvalid = 4'hF; s_wlast = 4'hF;
        s_awvalid = 4'hF;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk); #1;
            if (m_awvalid && m_awready) n_hs++;
        end
        n_tests++;
        if (n_hs != 4) begin
            n_fail++; $display("FAIL full_accepted: got %0d AWs want 4", n_hs);
        end
        n_tests++;
        if (m_awvalid !== 1'b0 || s_awready !== 4'b0) begin
            n_fail++; $display("FAIL full_blocked: awv=%b awr=%b want 0 0000", m_awvalid, s_awready);
        end
        @(negedge clk);
        m_wready = 1'b1;
        #1;
        n_tests++;
        if (m_wvalid !== 1'b1 || m_wlast !== 1'b1 || s_wready !== 4'b0001) begin
            n_fail++;
            $display("FAIL full_pop_beat: v=%b last=%b wr=%b want 1 1 0001", m_wvalid, m_wlast, s_wready);
        end
        @(negedge clk);
        m_wready = 1'b0;
        #1;
        n_tests++;
        if (m_awvalid !== 1'b0) begin
            n_fail++; $display("FAIL full_pop_edge: awv=%b want 0", m_awvalid);
        end
        @(negedge clk); #1;
        n_tests++;
        if (m_awvalid !== 1'b1 || m_awid[5:4] !== 2'd0 || s_awready !== 4'b0001) begin
            n_fail++;
            $display("FAIL full_resume: awv=%b src=%0d awr=%b want 1 0 0001", m_awvalid, m_awid[5:4], s_awready);
        end
        s_awvalid = '0; s_wvalid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_awready = 1'b1;
        s_awvalid[2] = 1'b1;
        repeat (2) @(negedge clk);
        s_awvalid[2] = 1'b0; s_awvalid[1] = 1'b1; m_awready = 1'b0;
        s_wvalid[2] = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (m_awvalid !== 1'b1 || m_awid[5:4] !== 2'd1 || m_wvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_pre: awv=%b src=%0d wv=%b want 1 1 1", m_awvalid, m_awid[5:4], m_wvalid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++;
        if (m_awvalid !== 1'b0 || m_wvalid !== 1'b0 || s_awready !== 4'b0 || s_wready !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: awv=%b wv=%b awr=%b wr=%b want all 0",
                     m_awvalid, m_wvalid, s_awready, s_wready);
        end
        s_awvalid = 4'b1001; m_awready = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (m_awvalid !== 1'b1 || m_awid[5:4] !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_rr_ptr: awv=%b src=%0d want 1 0", m_awvalid, m_awid[5:4]);
        end
        s_awvalid = '0; s_wvalid = '0;
    endtask

    task automatic test_stats();
        do_reset();
        m_awready = 1'b1;
        s_awvalid[3] = 1'b1;
        repeat (6) @(negedge clk);
        s_awvalid[3] = 1'b0;
        #1;
`ifdef AXI_WR_ARB_STATS_EN
        n_tests++;
        if (burst_cnt[3] !== 16'd3 || burst_cnt[2:0] !== '0) begin
            n_fail++; $display("FAIL stats_src3: got %h want 0003 others 0", burst_cnt);
        end
`else
        n_tests++;
        if (burst_cnt !== '0) begin
            n_fail++; $display("FAIL stats_disabled: got %h want 0", burst_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_w_order();
        test_fifo_full();
        test_reset_mid();
        test_stats();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
